// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial transmitter and its matching receiver:
// frame state encoding and the baud-counter width helper.
package serial_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // Baud counter width for a given bit period; never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned clks);
    return (clks < 2) ? 1 : $clog2(clks);
  endfunction

endpackage

// File: rtl/serial_tx_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses tick on the last
// cycle of each bit; clear holds it at zero.
module serial_tx_baud_tick
  import serial_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // >= rather than == so an out-of-range count still ends the bit and reloads.
  assign tick = !clear && (cnt >= LAST);

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      cnt <= '0;
    end else if (cnt >= LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Byte-wide serial transmitter: start bit, 8 data bits LSB first, optional
// parity bit, 1 or 2 stop bits; tx idles high.
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx,
  output logic       busy
);

  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  uart_state_t state;
  logic [7:0]  data_reg;
  logic [2:0]  bit_idx;
  logic        tick;
  logic        parity_bit;

  assign parity_bit = (^data_reg) ^ (PARITY_ODD != 0);
  assign busy       = ~data_ready;

  serial_tx_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clock(clock),
    .reset(reset),
    .clear(state == IDLE),
    .tick (tick)
  );

  // tx is loaded on each transition so it already carries the next bit's value.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      tx         <= 1'b1;
      data_ready <= 1'b1;
      bit_idx    <= '0;
      data_reg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (data_valid) begin
            data_reg   <= data_in;
            state      <= START;
            tx         <= 1'b0;
            data_ready <= 1'b0;
            bit_idx    <= '0;
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            tx    <= data_reg[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              if (PARITY_EN != 0) begin
                state <= PARITY;
                tx    <= parity_bit;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= data_reg[bit_idx + 3'd1];
            end
          end
        end
        PARITY: begin
          if (tick) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            if (bit_idx >= LAST_STOP) begin
              state      <= IDLE;
              data_ready <= 1'b1;
              bit_idx    <= '0;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        default: begin
          state      <= IDLE;
          tx         <= 1'b1;
          data_ready <= 1'b1;
          bit_idx    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: five configurations side by side, each frame
// checked bit slot by bit slot against a hand-written transmit-order pattern.
module tb_serial_tx;

  logic       clk;
  logic       rst  [5];
  logic       dv   [5];
  logic [7:0] din  [5];
  logic       rdy  [5];
  logic       tx_o [5];
  logic       bsy  [5];

  int n_checks = 0;
  int n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_tx #(.CLKS_PER_BIT(4)) u_d0 (
    .clock(clk), .reset(rst[0]), .data_in(din[0]), .data_valid(dv[0]),
    .data_ready(rdy[0]), .tx(tx_o[0]), .busy(bsy[0]));
  serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u_d1 (
    .clock(clk), .reset(rst[1]), .data_in(din[1]), .data_valid(dv[1]),
    .data_ready(rdy[1]), .tx(tx_o[1]), .busy(bsy[1]));
  serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u_d2 (
    .clock(clk), .reset(rst[2]), .data_in(din[2]), .data_valid(dv[2]),
    .data_ready(rdy[2]), .tx(tx_o[2]), .busy(bsy[2]));
  serial_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u_d3 (
    .clock(clk), .reset(rst[3]), .data_in(din[3]), .data_valid(dv[3]),
    .data_ready(rdy[3]), .tx(tx_o[3]), .busy(bsy[3]));
  serial_tx #(.CLKS_PER_BIT(2)) u_d4 (
    .clock(clk), .reset(rst[4]), .data_in(din[4]), .data_valid(dv[4]),
    .data_ready(rdy[4]), .tx(tx_o[4]), .busy(bsy[4]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // Waits (bounded) for ready, then presents b for exactly the accept edge.
  task automatic send(input int d, input logic [7:0] b, input string tag);
    int w = 0;
    while (rdy[d] !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_ready"}, 32'(rdy[d]), 32'd1);
    din[d] = b;
    dv[d]  = 1'b1;
    @(posedge clk);
    #1;
    dv[d]  = 1'b0;
    din[d] = ~b;
  endtask

  // Called just after the accept edge; pat lists the frame bits in send order.
  task automatic check_frame(input int d, input string pat, input int clks, input string tag);
    logic busy_ok;
    logic exp_bit;
    logic seen;
    busy_ok = 1'b1;
    for (int b = 0; b < pat.len(); b++) begin
      exp_bit = (pat[b] == "1");
      seen    = exp_bit;
      for (int c = 0; c < clks; c++) begin
        @(negedge clk);
        if (tx_o[d] !== exp_bit) seen = tx_o[d];
        if (bsy[d] !== 1'b1) busy_ok = 1'b0;
      end
      chk($sformatf("%s_bit%0d", tag, b), 32'(seen), 32'(exp_bit));
    end
    chk({tag, "_busy"}, 32'(busy_ok), 32'd1);
    @(negedge clk);
    chk({tag, "_idle_rdy"}, 32'(rdy[d]), 32'd1);
    chk({tag, "_idle_tx"}, 32'(tx_o[d]), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      rst[i] = 1'b0;
      dv[i]  = 1'b0;
      din[i] = 8'h00;
    end
    dv[0] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rst%0d_tx", i), 32'(tx_o[i]), 32'd1);
      chk($sformatf("rst%0d_rdy", i), 32'(rdy[i]), 32'd1);
      chk($sformatf("rst%0d_busy", i), 32'(bsy[i]), 32'd0);
      rst[i] = 1'b1;
    end
    dv[0] = 1'b0;
    @(negedge clk);

    // 8N1 at 4 clocks/bit
    send(0, 8'hA5, "a5");
    check_frame(0, "0101001011", 4, "a5");

    // parity variants
    send(1, 8'hA5, "a5_even");
    check_frame(1, "01010010101", 4, "a5_even");
    send(2, 8'hA5, "a5_odd");
    check_frame(2, "01010010111", 4, "a5_odd");
    send(1, 8'h01, "01_even");
    check_frame(1, "01000000011", 4, "01_even");

    // two stop bits
    send(3, 8'hFF, "ff_2stop");
    check_frame(3, "01111111111", 4, "ff_2stop");

    // minimum bit period
    send(4, 8'h80, "80_c2");
    check_frame(4, "0000000011", 2, "80_c2");

    // back-to-back with data_valid held and data_in changing mid-frame
    din[0] = 8'h3C;
    dv[0]  = 1'b1;
    @(posedge clk);
    #1;
    din[0] = 8'hC3;
    check_frame(0, "0001111001", 4, "b2b_3c");
    @(posedge clk);
    #1;
    din[0] = 8'h00;
    dv[0]  = 1'b0;
    check_frame(0, "0110000111", 4, "b2b_c3");

    // reset at cycle 15 of a frame, with data_valid asserted during reset
    send(0, 8'hA5, "abort");
    repeat (15) @(negedge clk);
    rst[0] = 1'b0;
    dv[0]  = 1'b1;
    din[0] = 8'hFF;
    @(negedge clk);
    chk("abort_tx", 32'(tx_o[0]), 32'd1);
    chk("abort_rdy", 32'(rdy[0]), 32'd1);
    chk("abort_busy", 32'(bsy[0]), 32'd0);
    rst[0] = 1'b1;
    dv[0]  = 1'b0;
    @(negedge clk);
    chk("abort_no_accept", 32'(rdy[0]), 32'd1);
    send(0, 8'h55, "55");
    check_frame(0, "0101010101", 4, "55");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
